multiplier_controller: RTL

MULTIPLIER_CONTROLLER -- requirements
Module: multiplier_controller

---
 rtl/multiplier_controller.sv | 99 +++++++++
 1 files changed

// File: rtl/multiplier_controller.sv
// rtl/multiplier_controller.sv - shift-add multiplier sequencer (LOAD, ADD/SHIFT per bit, DONE)
module multiplier_controller #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       product_lsb,
    output logic                       w_ctrl_Multiplicand,
    output logic                       w_ctrl_Product,
    output logic                       init_ctrl_Product,
    output logic                       addu_ctrl,
    output logic                       srl_ctrl_Product,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH):0]     iter_cnt
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        cnt_nxt             = cnt;
        w_ctrl_Multiplicand = 1'b0;
        w_ctrl_Product      = 1'b0;
        init_ctrl_Product   = 1'b0;
        addu_ctrl           = 1'b0;
        srl_ctrl_Product    = 1'b0;
        busy                = 1'b0;
        done                = 1'b0;
        case (state)
            S_IDLE: begin
                // Clearing on entry makes iter_cnt already 0 while LOAD is visible.
                if (start) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = '0;
                end
            end
            S_LOAD: begin
                w_ctrl_Multiplicand = 1'b1;
                w_ctrl_Product      = 1'b1;
                init_ctrl_Product   = 1'b1;
                busy                = 1'b1;
                cnt_nxt             = '0;
                state_nxt           = S_ADD;
            end
            S_ADD: begin
                addu_ctrl      = product_lsb;
                w_ctrl_Product = product_lsb;
                busy           = 1'b1;
                state_nxt      = S_SHIFT;
            end
            S_SHIFT: begin
                srl_ctrl_Product = 1'b1;
                busy             = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = S_ADD;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign iter_cnt = cnt;

endmodule
